// File: rtl/mmio_console.sv
`default_nettype none
// ============================================================================
//  Module   : mmio_console
//  Purpose  : Memory-mapped console / simulation-control responder on the CPU
//             data bus. CPU stores to TXDATA are queued in a first-word-fall-
//             through TX FIFO and drained on a byte-stream valid/ready port.
//             A single-entry RX register holds one incoming host byte. Writing
//             FINI_CODE to TXDATA lets the queue drain, then raises fini_o.
//  Ports    : clk_i / rst_i               clock, synchronous active-high reset
//             bus_addr_i                  byte address (bit 31 selects console)
//             bus_wvalid_i / bus_wdata_i  write request and data
//             bus_rvalid_i                read request
//             bus_stall_o                 hold the write request while high
//             bus_rdata_o / _valid_o      registered read data, 1-cycle pulse
//             tx_data_o/tx_valid_o/tx_ready_i  outgoing byte stream
//             rx_data_i/rx_valid_i/rx_ready_o  incoming byte stream
//             fini_o                      finish reached, sticky until reset
//  Register map (bus_addr_i[3:2]):
//             0 TXDATA (W)   1 STATUS (R)   2 RXDATA (R)   3 reads as zero
//  Revision : 1.0  initial release
// ============================================================================
module mmio_console #(
    parameter int unsigned TX_DEPTH  = 16,
    parameter logic [31:0] FINI_CODE = 32'h0002_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] bus_addr_i,
    input  logic        bus_wvalid_i,
    input  logic [31:0] bus_wdata_i,
    input  logic        bus_rvalid_i,
    output logic        bus_stall_o,
    output logic [31:0] bus_rdata_o,
    output logic        bus_rdata_valid_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic        fini_o
);

    localparam int unsigned c_ptr_w = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam int unsigned c_cnt_w = $clog2(TX_DEPTH + 1);

    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(TX_DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);

    localparam logic [1:0] c_off_txdata = 2'd0;
    localparam logic [1:0] c_off_status = 2'd1;
    localparam logic [1:0] c_off_rxdata = 2'd2;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [7:0]         r_mem [TX_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic               r_rx_full;
    logic [7:0]         r_rx_byte;

    logic [31:0]        r_rdata;
    logic               r_rdata_valid;

    logic               w_sel;
    logic [1:0]         w_off;
    logic               w_tx_wr;
    logic               w_is_fini;
    logic               w_tx_full;
    logic               w_tx_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_stall;
    logic               w_fini_req;
    logic               w_rd;
    logic               w_rx_rd;
    logic               w_rx_load;
    logic [7:0]         w_cnt8;
    logic [31:0]        w_status;
    logic [31:0]        w_rx_word;
    logic [31:0]        w_rdata_next;
    logic               w_unused_addr;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    assign w_sel         = bus_addr_i[31];
    assign w_off         = bus_addr_i[3:2];
    assign w_unused_addr = ^{bus_addr_i[30:4], bus_addr_i[1:0]};

    assign w_tx_wr   = bus_wvalid_i && w_sel && (w_off == c_off_txdata);
    assign w_is_fini = (bus_wdata_i == FINI_CODE);
    assign w_rd      = bus_rvalid_i && w_sel;
    assign w_rx_rd   = w_rd && (w_off == c_off_rxdata);

    // Full/empty come from the registered count, so a pop in the same cycle
    // never releases a stalled write early.
    assign w_tx_full  = (r_count == c_cnt_full);
    assign w_tx_empty = (r_count == '0);
    assign w_pop      = !w_tx_empty && tx_ready_i;

    // ------------------------------------------------------------------
    // Control state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        w_stall      = 1'b0;
        w_fini_req   = 1'b0;
        case (r_state)
            S_RUN: begin
                if (w_tx_wr) begin
                    if (w_is_fini) begin
                        // Finish request is accepted even with a full FIFO.
                        w_fini_req   = 1'b1;
                        w_state_next = S_DRAIN;
                    end else if (w_tx_full) begin
                        w_stall = 1'b1;
                    end else begin
                        w_push = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                // Leave only once the registered count has been seen at zero.
                if (w_tx_empty) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_DONE;
            end
            default: begin
                w_state_next = S_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // TX FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus_wdata_i[7:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX holding register
    // ------------------------------------------------------------------
    // A load requires the register to be empty, so it can never coincide
    // with the read that empties it; the next byte lands one cycle later.
    assign w_rx_load = rx_valid_i && !r_rx_full;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rx_full <= 1'b0;
            r_rx_byte <= 8'h00;
        end else if (w_rx_load) begin
            r_rx_full <= 1'b1;
            r_rx_byte <= rx_data_i;
        end else if (w_rx_rd) begin
            r_rx_full <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    assign w_cnt8    = 8'(r_count);
    assign w_status  = {16'h0000, w_cnt8, 4'b0000,
                        (r_state != S_RUN), r_rx_full, w_tx_full, w_tx_empty};
    assign w_rx_word = r_rx_full ? {1'b1, 23'b0, r_rx_byte} : 32'h0000_0000;

    always_comb begin
        w_rdata_next = 32'h0000_0000;
        case (w_off)
            c_off_status: w_rdata_next = w_status;
            c_off_rxdata: w_rdata_next = w_rx_word;
            default:      w_rdata_next = 32'h0000_0000;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rdata       <= 32'h0000_0000;
            r_rdata_valid <= 1'b0;
        end else begin
            r_rdata_valid <= w_rd;
            if (w_rd) begin
                r_rdata <= w_rdata_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus_stall_o       = w_stall;
    assign bus_rdata_o       = r_rdata;
    assign bus_rdata_valid_o = r_rdata_valid;
    assign tx_data_o         = r_mem[r_rd_ptr];
    assign tx_valid_o        = !w_tx_empty;
    assign rx_ready_o        = !r_rx_full;
    assign fini_o            = (r_state == S_DONE);

endmodule
`default_nettype wire
